prbs_gen_mc: RTL

//  Multi-channel successor to the single-channel PRBS source. One reference LFSR plus NUM_CH

---
 rtl/prbs_pkg.sv | 47 ++++
 rtl/prbs_gen_mc_lfsr.sv | 48 ++++
 rtl/prbs_gen_mc.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/prbs_pkg.sv
// Shared polynomial table, seed and config-word layout for the multi-channel PRBS source.
package prbs_pkg;

    typedef enum logic [2:0] {
        POLY_PRBS7  = 3'd0,
        POLY_PRBS9  = 3'd1,
        POLY_PRBS15 = 3'd2,
        POLY_PRBS23 = 3'd3,
        POLY_PRBS31 = 3'd4
    } poly_sel_t;

    // Bit indices (N-1, T-1) of the two feedback taps inside the LFSR state.
    typedef struct packed {
        logic [4:0] msb;
        logic [4:0] tap;
    } poly_taps_t;

    localparam int LFSR_W = 31;
    localparam logic [LFSR_W-1:0] SEED = '1;

    localparam int CFG_SEL_LSB = 0;
    localparam int CFG_SEL_W   = 3;
    localparam int CFG_DIV_LSB = 4;

    function automatic poly_sel_t decode_sel(input logic [CFG_SEL_W-1:0] raw);
        return (raw > 3'd4) ? POLY_PRBS31 : poly_sel_t'(raw);
    endfunction

    function automatic poly_taps_t poly_taps(input poly_sel_t sel);
        poly_taps_t t;
        case (sel)
            POLY_PRBS7:  t = '{msb: 5'd6,  tap: 5'd5};
            POLY_PRBS9:  t = '{msb: 5'd8,  tap: 5'd4};
            POLY_PRBS15: t = '{msb: 5'd14, tap: 5'd13};
            POLY_PRBS23: t = '{msb: 5'd22, tap: 5'd17};
            default:     t = '{msb: 5'd30, tap: 5'd27};
        endcase
        return t;
    endfunction

    function automatic logic [LFSR_W-1:0] poly_mask(input poly_sel_t sel);
        poly_taps_t t;
        t = poly_taps(sel);
        return SEED >> (5'd30 - t.msb);
    endfunction

endpackage

// File: rtl/prbs_gen_mc_lfsr.sv
// prbs_lfsr: one Fibonacci LFSR lane with seed reload, freeze (en=0) and lock-up recovery.
module prbs_lfsr
    import prbs_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       load,
    input  logic [2:0] sel,
    output logic       bit_out
);

    poly_sel_t         psel;
    poly_taps_t        taps;
    logic [LFSR_W-1:0] mask;
    logic [LFSR_W-1:0] state;
    logic [LFSR_W-1:0] next_state;
    logic              fb;

    // Bits above the selected length stay zero, so a shorter poly never sees stale upper state.
    always_comb begin
        psel       = poly_sel_t'(sel);
        taps       = poly_taps(psel);
        mask       = poly_mask(psel);
        fb         = state[taps.msb] ^ state[taps.tap];
        next_state = {state[LFSR_W-2:0], fb} & mask;
    end

    // NOTE: state registers use non-blocking assignments so every lane sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= SEED;
            bit_out <= 1'b0;
        end else if (load) begin
            state   <= SEED & mask;
            bit_out <= 1'b0;
        end else if (en) begin
            if (state == '0) begin
                state   <= SEED & mask;
                bit_out <= 1'b0;
            end else begin
                state   <= next_state;
                bit_out <= fb;
            end
        end
    end

endmodule

// File: rtl/prbs_gen_mc.sv
// prbs_gen_mc: reference PRBS plus NUM_CH chip-delayed copies driving bipolar DAC lanes.
// Optional per-channel +/-1 demodulator enabled by defining PRBS_DEMOD_EN.
module prbs_gen_mc
    import prbs_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int DAC_W  = 14,
    parameter int DLY_W  = 24,
    parameter int DIV_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              S_AXIS_CFG_tdata,
    input  logic                     S_AXIS_CFG_tvalid,
    input  logic [NUM_CH*DLY_W-1:0]  chip_delay,
    output logic                     chip_stb,
    output logic                     prbs_ref,
    output logic [NUM_CH-1:0]        prbs_del,
    output logic [NUM_CH*16-1:0]     M_AXIS_DAC_tdata,
    output logic                     M_AXIS_DAC_tvalid
`ifdef PRBS_DEMOD_EN
    ,
    input  logic [NUM_CH*16-1:0]     S_AXIS_DATA_tdata,
    input  logic                     S_AXIS_DATA_tvalid,
    output logic [NUM_CH*16-1:0]     M_AXIS_DEMOD_tdata,
    output logic                     M_AXIS_DEMOD_tvalid
`endif
);

    localparam int LANE_W = 16;
    localparam logic [DAC_W-1:0]  DAC_POS  = {1'b0, {(DAC_W-1){1'b1}}};
    localparam logic [DAC_W-1:0]  DAC_NEG  = {1'b1, {(DAC_W-1){1'b0}}};
    localparam logic [LANE_W-1:0] LANE_POS = {{(LANE_W-DAC_W){1'b0}}, DAC_POS};
    localparam logic [LANE_W-1:0] LANE_NEG = {{(LANE_W-DAC_W){1'b0}}, DAC_NEG};

    logic                    cfg_wr;
    poly_sel_t               sel_q;
    poly_sel_t               sel_new;
    poly_sel_t               sel_eff;
    logic [DIV_W-1:0]        div_q;
    logic [DIV_W-1:0]        div_cnt;
    logic [DLY_W-1:0]        dly_cnt;
    logic [NUM_CH*DLY_W-1:0] delay_q;
    logic                    active;
    logic                    cfg_unused;

    assign cfg_wr     = S_AXIS_CFG_tvalid;
    assign sel_new    = decode_sel(S_AXIS_CFG_tdata[CFG_SEL_LSB +: CFG_SEL_W]);
    // The reload on a config write must already use the incoming poly length.
    assign sel_eff    = cfg_wr ? sel_new : sel_q;
    assign chip_stb   = active && (div_cnt == div_q);
    assign cfg_unused = ^{S_AXIS_CFG_tdata[31:CFG_DIV_LSB+DIV_W], S_AXIS_CFG_tdata[3]};
    assign M_AXIS_DAC_tvalid = active;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active  <= 1'b0;
            sel_q   <= POLY_PRBS31;
            div_q   <= '0;
            delay_q <= '0;
        end else begin
            active <= 1'b1;
            if (cfg_wr) begin
                sel_q   <= sel_new;
                div_q   <= S_AXIS_CFG_tdata[CFG_DIV_LSB +: DIV_W];
                delay_q <= chip_delay;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            dly_cnt <= '0;
        end else if (cfg_wr) begin
            div_cnt <= '0;
            dly_cnt <= '0;
        end else begin
            div_cnt <= (div_cnt == div_q) ? '0 : div_cnt + 1'b1;
            if (chip_stb && (dly_cnt != '1)) begin
                dly_cnt <= dly_cnt + 1'b1;
            end
        end
    end

    prbs_lfsr u_ref (
        .clk     (clk),
        .rst     (rst),
        .en      (chip_stb),
        .load    (cfg_wr),
        .sel     (sel_eff),
        .bit_out (prbs_ref)
    );

    // A channel stays frozen at its seed until dly_cnt reaches its delay, so it lags ref exactly.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic ch_en;
        assign ch_en = chip_stb && (dly_cnt >= delay_q[i*DLY_W +: DLY_W]);

        prbs_lfsr u_lfsr (
            .clk     (clk),
            .rst     (rst),
            .en      (ch_en),
            .load    (cfg_wr),
            .sel     (sel_eff),
            .bit_out (prbs_del[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            M_AXIS_DAC_tdata <= {NUM_CH{LANE_NEG}};
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                M_AXIS_DAC_tdata[i*LANE_W +: LANE_W] <= prbs_del[i] ? LANE_POS : LANE_NEG;
            end
        end
    end

`ifdef PRBS_DEMOD_EN
    logic [NUM_CH*16-1:0] demod_next;
    logic [DAC_W-1:0]     demod_x;
    logic [DAC_W-1:0]     demod_y;
    logic                 demod_unused;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        demod_next   = '0;
        demod_x      = '0;
        demod_y      = '0;
        demod_unused = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            demod_x = S_AXIS_DATA_tdata[i*LANE_W +: DAC_W];
            if (!prbs_del[i]) begin
                demod_y = demod_x;
            end else if (demod_x == DAC_NEG) begin
                demod_y = DAC_POS;
            end else begin
                demod_y = -demod_x;
            end
            demod_next[i*LANE_W +: DAC_W] = demod_y;
            demod_unused = demod_unused ^ (^S_AXIS_DATA_tdata[i*LANE_W+DAC_W +: LANE_W-DAC_W]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            M_AXIS_DEMOD_tdata  <= '0;
            M_AXIS_DEMOD_tvalid <= 1'b0;
        end else begin
            M_AXIS_DEMOD_tdata  <= demod_next;
            M_AXIS_DEMOD_tvalid <= S_AXIS_DATA_tvalid;
        end
    end
`endif

endmodule
